// File: rtl/ysyx_25030085_pkg.sv
// Shared defaults for the ysyx_25030085 register file slice.
//   XLEN_DEF : default register data width
//   NREG_DEF : default register count
//   X0       : index of the hardwired-zero register
package ysyx_25030085_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int X0       = 0;

endpackage

// File: rtl/ysyx_25030085_scoreboard.sv
// Per-register busy tracking for in-flight writes.
// An issued instruction marks its destination busy. A writeback clears
// the busy bit of its destination. Flush clears every bit.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   iss_en, iss_rd : issue event and its destination register
//   wen, waddr     : writeback event and its destination register
//   flush          : discard all outstanding writes
//   busy           : one bit per register, bit X0 always 0
module ysyx_25030085_scoreboard
    import ysyx_25030085_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic            flush,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;

    // Clear is applied before set, so an issue and a writeback to the
    // same register in one cycle leave it busy. Flush overrides both.
    always_comb begin
        busy_next = busy;
        if (wen) begin
            busy_next[waddr] = 1'b0;
        end
        if (iss_en && (iss_rd != AW'(X0))) begin
            busy_next[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[X0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/ysyx_25030085_regfile_sb.sv
// Register file with an integrated busy scoreboard for hazard detection.
// Reads are combinational; x0 reads as zero and cannot be written.
// Optional feature macro: YSYX_25030085_RF_BYPASS_EN
//   defined   : a read of the register being written this cycle returns
//               wdata and the busy bit it will have after the edge
//   undefined : reads return the stored value and current busy bit
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   raddr  [NRP*AW]      : read addresses, port i at [i*AW +: AW]
//   rdata  [NRP*XLEN]    : read data, port i at [i*XLEN +: XLEN]
//   rbusy  [NRP]         : port i reads a register with a pending write
//   wen, waddr, wdata    : writeback
//   iss_en, iss_rd       : instruction issue with destination
//   flush                : clear all pending writes
//   stall                : OR of rbusy
module ysyx_25030085_regfile_sb
    import ysyx_25030085_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRP  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic                stall
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else if (wen && (waddr != AW'(X0))) begin
            regs[waddr] <= wdata;
        end
    end

    ysyx_25030085_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .iss_en (iss_en),
        .iss_rd (iss_rd),
        .wen    (wen),
        .waddr  (waddr),
        .flush  (flush),
        .busy   (busy)
    );

    for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] stored;

        assign ra     = raddr[gi*AW +: AW];
        assign stored = (ra == AW'(X0)) ? '0 : regs[ra];

`ifdef YSYX_25030085_RF_BYPASS_EN
        // Forwarding is gated by rst_n so that rdata stays 0 in reset.
        logic hit;
        assign hit = rst_n && wen && (waddr != AW'(X0)) && (waddr == ra);
        assign rdata[gi*XLEN +: XLEN] = hit ? wdata : stored;
        assign rbusy[gi] = hit ? (iss_en && !flush && (iss_rd == ra)) : busy[ra];
`else
        assign rdata[gi*XLEN +: XLEN] = stored;
        assign rbusy[gi] = busy[ra];
`endif
    end

    assign stall = |rbusy;

endmodule

// File: tb/tb_ysyx_25030085_regfile_sb.sv
module tb_ysyx_25030085_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst_n;
    logic [NRP*AW-1:0]   raddr;
    logic [NRP*XLEN-1:0] rdata;
    logic [NRP-1:0]      rbusy;
    logic                wen;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                stall;

    ysyx_25030085_regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRP  (NRP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr  (raddr),
        .rdata  (rdata),
        .rbusy  (rbusy),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .iss_en (iss_en),
        .iss_rd (iss_rd),
        .flush  (flush),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic        stl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef YSYX_25030085_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        iss_en = 1'b0;
        iss_rd = '0;
        flush  = 1'b0;
    endtask

    // Drive a read address and queue what that port should show.
    task automatic expect_rd(input string tag, input int port, input logic [AW-1:0] addr,
                             input logic [31:0] data, input logic busy, input logic stl);
        exp_t e;
        raddr[port*AW +: AW] = addr;
        e.tag  = tag;
        e.port = port;
        e.data = data;
        e.busy = busy;
        e.stl  = stl;
        exp_q.push_back(e);
    endtask

    // Pop every queued expectation and compare against the settled outputs.
    task automatic check_all();
        exp_t e;
        logic [31:0] got_d;
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty: got 0 expectations required at least 1");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got_d = rdata[e.port*XLEN +: XLEN];
            checks++;
            assert (got_d === e.data) else begin
                errors++;
                $error("FAIL %s rdata%0d got %h exp %h", e.tag, e.port, got_d, e.data);
            end
            checks++;
            assert (rbusy[e.port] === e.busy) else begin
                errors++;
                $error("FAIL %s rbusy%0d got %b exp %b", e.tag, e.port, rbusy[e.port], e.busy);
            end
            checks++;
            assert (stall === e.stl) else begin
                errors++;
                $error("FAIL %s stall got %b exp %b", e.tag, stall, e.stl);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        raddr = '0;
        idle();
        #2;
        expect_rd("reset_init", 0, 5'd5, 32'h0, 1'b0, 1'b0);
        check_all();
        cyc();
        rst_n = 1'b1;
        cyc();

        // write x5 then read it back
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cyc();
        idle();
        expect_rd("x5_write", 0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        check_all();

        // async reset clears x5; wen/iss_en during reset are ignored
        rst_n = 1'b0;
        wen = 1'b1; waddr = 5'd6; wdata = 32'h11111111;
        iss_en = 1'b1; iss_rd = 5'd6;
        expect_rd("reset_x5", 0, 5'd5, 32'h0, 1'b0, 1'b0);
        expect_rd("reset_x6", 1, 5'd6, 32'h0, 1'b0, 1'b0);
        check_all();
        cyc();
        cyc();
        idle();
        rst_n = 1'b1;
        cyc();
        expect_rd("post_reset_x6", 0, 5'd6, 32'h0, 1'b0, 1'b0);
        expect_rd("post_reset_x0", 1, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all();

        // x0 write dropped
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        expect_rd("x0_same", 0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all();
        cyc();
        idle();
        expect_rd("x0_after", 0, 5'd0, 32'h0, 1'b0, 1'b0);
        check_all();

        // RAW hazard on x7
        iss_en = 1'b1; iss_rd = 5'd7;
        cyc();
        idle();
        expect_rd("haz_busy", 0, 5'd7, 32'h0, 1'b1, 1'b1);
        check_all();
        wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        expect_rd("haz_wb_same", 0, 5'd7, BYP ? 32'h12345678 : 32'h0, !BYP, !BYP);
        check_all();
        cyc();
        idle();
        expect_rd("haz_done", 0, 5'd7, 32'h12345678, 1'b0, 1'b0);
        expect_rd("haz_done_p1", 1, 5'd7, 32'h12345678, 1'b0, 1'b0);
        check_all();

        // issue and writeback to x3 in the same cycle: set wins
        iss_en = 1'b1; iss_rd = 5'd3;
        cyc();
        iss_en = 1'b1; iss_rd = 5'd3;
        wen = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
        cyc();
        idle();
        expect_rd("simul_p0", 0, 5'd3, 32'hCAFEF00D, 1'b1, 1'b1);
        expect_rd("simul_p1", 1, 5'd3, 32'hCAFEF00D, 1'b1, 1'b1);
        check_all();

        // flush with pending x1, x2, x9 (and x3); flush beats a same-cycle issue
        iss_en = 1'b1; iss_rd = 5'd1; cyc();
        iss_rd = 5'd2; cyc();
        iss_rd = 5'd9; cyc();
        idle();
        expect_rd("pre_flush_x1", 0, 5'd1, 32'h0, 1'b1, 1'b1);
        expect_rd("pre_flush_x9", 1, 5'd9, 32'h0, 1'b1, 1'b1);
        check_all();
        flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd2;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h99990009;
        cyc();
        idle();
        expect_rd("flush_x2", 0, 5'd2, 32'h0, 1'b0, 1'b0);
        expect_rd("flush_x9", 1, 5'd9, 32'h99990009, 1'b0, 1'b0);
        check_all();
        expect_rd("flush_x1", 0, 5'd1, 32'h0, 1'b0, 1'b0);
        expect_rd("flush_x3", 1, 5'd3, 32'hCAFEF00D, 1'b0, 1'b0);
        check_all();

        // same-cycle read of a register being written
        wen = 1'b1; waddr = 5'd4; wdata = 32'h0BADC0DE;
        cyc();
        idle();
        raddr = '0;
        wen = 1'b1; waddr = 5'd4; wdata = 32'hA5A5A5A5;
        expect_rd("bypass_p1", 1, 5'd4, BYP ? 32'hA5A5A5A5 : 32'h0BADC0DE, 1'b0, 1'b0);
        check_all();
        cyc();
        idle();
        expect_rd("bypass_after", 1, 5'd4, 32'hA5A5A5A5, 1'b0, 1'b0);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion required completion");
        $fatal(1, "timeout");
    end

endmodule
